// File: rtl/onewire_tx.sv
// Single-wire open-drain initiator: reset pulse, presence check, then one byte LSB first
// as pulse-width slots. Define ONEWIRE_TX_CONFLICT_EN to abort when the peer holds the bus.
module onewire_tx #(
    parameter int RST_LOW     = 20,
    parameter int PRES_SAMPLE = 6,
    parameter int PRES_WIN    = 16,
    parameter int SLOT        = 12,
    parameter int BIT1_LOW    = 2,
    parameter int BIT0_LOW    = 8,
    parameter int REC         = 2,
    parameter int CW          = 24
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        dinout,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       presence_ok,
    output logic       collision
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_PULSE = 3'd1,
        S_PRES_WAIT = 3'd2,
        S_SLOT_LOW  = 3'd3,
        S_SLOT_REL  = 3'd4,
        S_RECOVER   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [CW-1:0] RST_END   = CW'(RST_LOW - 1);
    localparam logic [CW-1:0] PRES_AT   = CW'(PRES_SAMPLE);
    localparam logic [CW-1:0] PRES_END  = CW'(PRES_WIN - 1);
    localparam logic [CW-1:0] LOW1_END  = CW'(BIT1_LOW - 1);
    localparam logic [CW-1:0] LOW0_END  = CW'(BIT0_LOW - 1);
    localparam logic [CW-1:0] REL1_END  = CW'(SLOT - BIT1_LOW - 1);
    localparam logic [CW-1:0] REL0_END  = CW'(SLOT - BIT0_LOW - 1);
    localparam logic [CW-1:0] REC_END   = CW'(REC - 1);
    localparam logic [CW-1:0] SYNC_SKIP = CW'(2);

    state_t        state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [7:0]    shreg_r, shreg_n;
    logic [2:0]    bit_idx_r, bit_idx_n;
    logic          drive_low_r, drive_low_n;
    logic          busy_n, done_n, presence_n, collision_n;
    logic          sync1_r, sync2_r;
    logic          low_prev_r, low_prev_n;
    logic [CW-1:0] low_end_s, rel_end_s;

    // Open-drain pad: only ever pulls low, otherwise released to the pull-up.
    assign dinout = drive_low_r ? 1'b0 : 1'bz;

    assign low_end_s = shreg_r[0] ? LOW1_END : LOW0_END;
    assign rel_end_s = shreg_r[0] ? REL1_END : REL0_END;

    // Next-state, counter and output-register logic.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r + CW'(1);
        shreg_n     = shreg_r;
        bit_idx_n   = bit_idx_r;
        drive_low_n = drive_low_r;
        busy_n      = busy;
        done_n      = 1'b0;
        presence_n  = presence_ok;
        collision_n = collision;
        low_prev_n  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    shreg_n     = data;
                    bit_idx_n   = 3'd0;
                    presence_n  = 1'b0;
                    collision_n = 1'b0;
                    drive_low_n = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = S_RST_PULSE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RST_PULSE: begin
                if (cnt_r == RST_END) begin
                    drive_low_n = 1'b0;
                    state_n     = S_PRES_WAIT;
                end else begin
                    state_n = S_RST_PULSE;
                end
            end
            S_PRES_WAIT: begin
                if (cnt_r == PRES_AT) begin
                    presence_n = ~sync2_r;
                end else begin
                    presence_n = presence_ok;
                end
                // presence_ok is already registered here because PRES_WIN > PRES_SAMPLE.
                if (cnt_r == PRES_END) begin
                    if (presence_ok) begin
                        drive_low_n = 1'b1;
                        state_n     = S_SLOT_LOW;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end else begin
                    state_n = S_PRES_WAIT;
                end
            end
            S_SLOT_LOW: begin
                if (cnt_r == low_end_s) begin
                    drive_low_n = 1'b0;
                    state_n     = S_SLOT_REL;
                end else begin
                    state_n = S_SLOT_LOW;
                end
            end
            S_SLOT_REL: begin
                if (cnt_r == rel_end_s) begin
                    state_n = S_RECOVER;
                end else begin
                    state_n = S_SLOT_REL;
                end
            end
            S_RECOVER: begin
                if (cnt_r == REC_END) begin
                    shreg_n = {1'b0, shreg_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        bit_idx_n   = bit_idx_r + 3'd1;
                        drive_low_n = 1'b1;
                        state_n     = S_SLOT_LOW;
                    end
                end else begin
                    state_n = S_RECOVER;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                drive_low_n = 1'b0;
                busy_n      = 1'b0;
                state_n     = S_IDLE;
            end
        endcase
`ifdef ONEWIRE_TX_CONFLICT_EN
        // Skip the first two released cycles: the synchronizer still shows our own low.
        if ((state_r == S_RECOVER) || ((state_r == S_SLOT_REL) && (cnt_r >= SYNC_SKIP))) begin
            low_prev_n = ~sync2_r;
            if (!sync2_r && low_prev_r) begin
                collision_n = 1'b1;
                drive_low_n = 1'b0;
                busy_n      = 1'b0;
                done_n      = 1'b1;
                state_n     = S_DONE;
            end else begin
                collision_n = collision;
            end
        end else begin
            low_prev_n = 1'b0;
        end
`else
        collision_n = 1'b0;
`endif
        if (state_n != state_r) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt_n;
        end
    end

    // State, datapath and output registers; line sense synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            shreg_r     <= 8'h00;
            bit_idx_r   <= 3'd0;
            drive_low_r <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            presence_ok <= 1'b0;
            collision   <= 1'b0;
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            low_prev_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            shreg_r     <= shreg_n;
            bit_idx_r   <= bit_idx_n;
            drive_low_r <= drive_low_n;
            busy        <= busy_n;
            done        <= done_n;
            presence_ok <= presence_n;
            collision   <= collision_n;
            sync1_r     <= dinout;
            sync2_r     <= sync1_r;
            low_prev_r  <= low_prev_n;
        end
    end

endmodule

// File: tb/tb_onewire_tx.sv
// Self-checking bench for onewire_tx: table of transactions with a low-pulse scoreboard,
// plus hand-written sequences for hold-start and mid-slot reset.
module tb_onewire_tx;

    localparam int RST_LOW     = 20;
    localparam int PRES_SAMPLE = 6;
    localparam int PRES_WIN    = 16;
    localparam int SLOT        = 12;
    localparam int BIT1_LOW    = 2;
    localparam int BIT0_LOW    = 8;
    localparam int REC         = 2;
    localparam int CW          = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       busy, done, presence_ok, collision;
    logic       peer_low;
    wire        line;

    pullup (line);
    assign line = peer_low ? 1'b0 : 1'bz;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit mon_en = 1'b0;
    int run = 0;

    typedef struct {
        logic [7:0] data;
        bit         pres;
        bit         hold;
        bit         coll;
    } vec_t;

    vec_t vecs[6];

    onewire_tx #(
        .RST_LOW(RST_LOW), .PRES_SAMPLE(PRES_SAMPLE), .PRES_WIN(PRES_WIN), .SLOT(SLOT),
        .BIT1_LOW(BIT1_LOW), .BIT0_LOW(BIT0_LOW), .REC(REC), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .dinout(line), .start(start), .data(data),
        .busy(busy), .done(done), .presence_ok(presence_ok), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Measure every low pulse the DUT drives and compare against the expected widths.
    always @(negedge clk) begin
        if (!mon_en) begin
            run = 0;
        end else if (line === 1'b0 && !peer_low) begin
            run++;
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_low_pulse", run, 0);
            end else begin
                check("low_pulse_width", run, exp_q.pop_front());
            end
            run = 0;
        end
    end

    task automatic run_txn(input logic [7:0] d, input bit pres, input bit hold, input bit coll);
        int nbits, exp_done, cb, e;
        bit exp_coll, seen;
        nbits    = pres ? 8 : 0;
        exp_coll = 1'b0;
        cb       = RST_LOW + PRES_WIN + 2 * (SLOT + REC) + BIT1_LOW;
`ifdef ONEWIRE_TX_CONFLICT_EN
        if (coll && pres) begin
            nbits    = 3;
            exp_coll = 1'b1;
        end
`endif
        exp_done = exp_coll ? cb + 7 : RST_LOW + PRES_WIN + nbits * (SLOT + REC);
        exp_q.push_back(RST_LOW);
        for (int i = 0; i < nbits; i++) exp_q.push_back(d[i] ? BIT1_LOW : BIT0_LOW);
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_line_low", line, 0);
        check("accept_presence_cleared", presence_ok, 0);
        seen = 1'b0;
        e    = 0;
        while (!seen && e < 1000) begin
            @(posedge clk);
            #1;
            e++;
            if (pres && e == RST_LOW + 3)  peer_low = 1'b1;
            if (pres && e == RST_LOW + 10) peer_low = 1'b0;
            if (coll && e == cb + 3)       peer_low = 1'b1;
            if (coll && e == cb + 7)       peer_low = 1'b0;
            if (done) seen = 1'b1;
        end
        peer_low = 1'b0;
        check("done_seen", seen, 1);
        check("done_cycle", e, exp_done);
        check("done_busy", busy, 0);
        check("presence_ok", presence_ok, pres);
        check("collision", collision, exp_coll);
        @(posedge clk);
        #1;
        if (hold) start = 1'b0;
        check("done_one_cycle", done, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, pres: 1'b1, hold: 1'b0, coll: 1'b0};
        vecs[1] = '{data: 8'hFF, pres: 1'b0, hold: 1'b0, coll: 1'b0};
        vecs[2] = '{data: 8'h00, pres: 1'b1, hold: 1'b0, coll: 1'b0};
        vecs[3] = '{data: 8'h5A, pres: 1'b1, hold: 1'b1, coll: 1'b0};
        vecs[4] = '{data: 8'h3C, pres: 1'b1, hold: 1'b0, coll: 1'b0};
        vecs[5] = '{data: 8'hFF, pres: 1'b1, hold: 1'b0, coll: 1'b1};

        rst      = 1'b1;
        start    = 1'b1;
        data     = 8'h00;
        peer_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_presence", presence_ok, 0);
        check("reset_collision", collision, 0);
        check("reset_line_released", line, 1);
        start = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].data, vecs[v].pres, vecs[v].hold, vecs[v].coll);
            if (vecs[v].hold) begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("hold_no_retrigger", busy, 0);
                end
                check("hold_no_extra_pulse", exp_q.size(), 0);
            end
        end

        // Reset during the low phase of bit 3 (a 0 bit of 8'hA5).
        exp_q.push_back(RST_LOW);
        for (int i = 0; i < 3; i++) exp_q.push_back(i[0] ? BIT0_LOW : BIT1_LOW);
        data  = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= RST_LOW + PRES_WIN + 3 * (SLOT + REC) + 2; e++) begin
            @(posedge clk);
            #1;
            if (e == RST_LOW + 3)  peer_low = 1'b1;
            if (e == RST_LOW + 10) peer_low = 1'b0;
        end
        check("abort_mid_slot_low", line, 0);
        check("abort_prior_slots", exp_q.size(), 0);
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_line_released", line, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_presence", presence_ok, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        exp_q.delete();
        mon_en = 1'b1;

        run_txn(8'hC3, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
